// File: rtl/stream_demux3.sv
// stream_demux3: 1-to-3 valid/ready byte-stream demux with
// packet-locked routing and a one-beat register per output channel.
module stream_demux3 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              sel_1,
  input  logic              sel_2,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic              out0_last,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic              out1_last,
  output logic              out2_valid,
  input  logic              out2_ready,
  output logic [DATA_W-1:0] out2_data,
  output logic              out2_last,
  output logic              busy,
  output logic [1:0]        dest
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                   state_q, state_d;
  logic [1:0]               lock_q, lock_d;
  logic [1:0]               sel_dest, dest_w;
  logic [2:0]               vld_q, vld_d;
  logic [2:0]               lst_q, lst_d;
  logic [2:0][DATA_W-1:0]   dat_q, dat_d;
  logic                     busy_q, busy_d;
  logic [2:0]               rdy;
  logic                     acc;

  assign rdy = {out2_ready, out1_ready, out0_ready};

  // sel_2 outranks sel_1, so code 3 never appears
  always_comb begin
    sel_dest = 2'd0;
    priority case (1'b1)
      sel_2:   sel_dest = 2'd2;
      sel_1:   sel_dest = 2'd1;
      default: sel_dest = 2'd0;
    endcase
  end

  assign dest_w = (state_q == BUSY) ? lock_q : sel_dest;

  always_comb begin
    in_ready = 1'b0;
    case (dest_w)
      2'd1:    in_ready = !vld_q[1] || out1_ready;
      2'd2:    in_ready = !vld_q[2] || out2_ready;
      default: in_ready = !vld_q[0] || out0_ready;
    endcase
  end

  assign acc = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    vld_d   = vld_q;
    dat_d   = dat_q;
    lst_d   = lst_q;
    for (int k = 0; k < 3; k++) begin
      if (acc && dest_w == 2'(k)) begin
        vld_d[k] = 1'b1;
        dat_d[k] = in_data;
        lst_d[k] = in_last;
      end else if (vld_q[k] && rdy[k]) begin
        vld_d[k] = 1'b0;
      end
    end
    if (acc) begin
      if (in_last) begin
        state_d = IDLE;
      end else begin
        state_d = BUSY;
        lock_d  = dest_w;
      end
    end
    busy_d = (state_d == BUSY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lock_q  <= 2'd0;
      vld_q   <= '0;
      dat_q   <= '0;
      lst_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      vld_q   <= vld_d;
      dat_q   <= dat_d;
      lst_q   <= lst_d;
      busy_q  <= busy_d;
    end
  end

  assign out0_valid = vld_q[0];
  assign out1_valid = vld_q[1];
  assign out2_valid = vld_q[2];
  assign out0_data  = dat_q[0];
  assign out1_data  = dat_q[1];
  assign out2_data  = dat_q[2];
  assign out0_last  = lst_q[0];
  assign out1_last  = lst_q[1];
  assign out2_last  = lst_q[2];
  assign busy       = busy_q;
  assign dest       = dest_w;

endmodule

// File: tb/tb_stream_demux3.sv
// tb_stream_demux3: directed and random stimulus against a
// packet-level reference model of the 1-to-3 stream demux.
module tb_stream_demux3;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_last;
  logic [7:0] in_data;
  logic       sel_1, sel_2;
  logic       out0_valid, out0_ready, out0_last;
  logic       out1_valid, out1_ready, out1_last;
  logic       out2_valid, out2_ready, out2_last;
  logic [7:0] out0_data, out1_data, out2_data;
  logic       busy;
  logic [1:0] dest;

  int n_vec = 0;
  int n_err = 0;

  // reference model: each channel holds at most one beat
  int         m_cnt [3];
  logic [7:0] m_dat [3];
  logic       m_lst [3];
  bit         m_in_pkt;
  int         m_route;

  always #5 clk = ~clk;

  stream_demux3 #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last),
    .sel_1(sel_1), .sel_2(sel_2),
    .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out0_data(out0_data), .out0_last(out0_last),
    .out1_valid(out1_valid), .out1_ready(out1_ready),
    .out1_data(out1_data), .out1_last(out1_last),
    .out2_valid(out2_valid), .out2_ready(out2_ready),
    .out2_data(out2_data), .out2_last(out2_last),
    .busy(busy), .dest(dest)
  );

  task automatic cmp(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) m_cnt[k] = 0;
    m_in_pkt = 0;
    m_route  = 0;
  endtask

  function automatic int pick();
    if (m_in_pkt) return m_route;
    if (sel_2) return 2;
    return sel_1 ? 1 : 0;
  endfunction

  function automatic bit cons_ready(int k);
    case (k)
      1:       return out1_ready;
      2:       return out2_ready;
      default: return out0_ready;
    endcase
  endfunction

  task automatic drive(input bit v, input logic [7:0] d, input bit l,
                       input bit s1, input bit s2,
                       input bit r0, input bit r1, input bit r2);
    in_valid = v; in_data = d; in_last = l;
    sel_1 = s1; sel_2 = s2;
    out0_ready = r0; out1_ready = r1; out2_ready = r2;
  endtask

  task automatic check_outputs(input int d, input bit rdy);
    logic       v [3];
    logic [7:0] dd [3];
    logic       ll [3];
    v[0] = out0_valid; v[1] = out1_valid; v[2] = out2_valid;
    dd[0] = out0_data; dd[1] = out1_data; dd[2] = out2_data;
    ll[0] = out0_last; ll[1] = out1_last; ll[2] = out2_last;
    cmp("in_ready", 32'(in_ready), 32'(rdy));
    cmp("busy", 32'(busy), 32'(m_in_pkt));
    cmp("dest", 32'(dest), 32'(d));
    for (int k = 0; k < 3; k++) begin
      cmp($sformatf("out%0d_valid", k), 32'(v[k]), 32'(m_cnt[k] > 0));
      if (m_cnt[k] > 0) begin
        cmp($sformatf("out%0d_data", k), 32'(dd[k]), 32'(m_dat[k]));
        cmp($sformatf("out%0d_last", k), 32'(ll[k]), 32'(m_lst[k]));
      end
    end
  endtask

  // called at a falling edge with inputs already applied
  task automatic cycle();
    int d;
    bit rdy, acc;
    #1;
    d   = pick();
    rdy = (m_cnt[d] == 0) || cons_ready(d);
    check_outputs(d, rdy);
    acc = in_valid && rdy;
    for (int k = 0; k < 3; k++)
      if (m_cnt[k] > 0 && cons_ready(k)) m_cnt[k]--;
    if (acc) begin
      m_cnt[d] = 1;
      m_dat[d] = in_data;
      m_lst[d] = in_last;
      m_in_pkt = !in_last;
      if (!in_last) m_route = d;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 8'h00, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    #1;
    check_outputs(0, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // decode: one beat to each channel, consumers stalled
    drive(1, 8'hA5, 1, 0, 0, 0, 0, 0);
    cycle();
    cmp("dec0_data", 32'(out0_data), 32'h0A5);
    cmp("dec0_others", 32'({out2_valid, out1_valid}), 32'h0);
    drive(1, 8'h3C, 1, 1, 0, 0, 0, 0);
    cycle();
    cmp("dec1_data", 32'(out1_data), 32'h03C);
    drive(1, 8'h5A, 1, 1, 1, 0, 0, 0);
    cycle();
    cmp("dec2_data", 32'(out2_data), 32'h05A);
    drive(0, 8'h00, 0, 0, 0, 1, 1, 1);
    cycle();
    cycle();

    // route lock: select moves to ch2 mid-packet
    drive(1, 8'h10, 0, 1, 0, 1, 1, 1);
    cycle();
    cmp("lock_busy", 32'(busy), 32'h1);
    drive(1, 8'h11, 0, 1, 0, 1, 1, 1);
    cycle();
    drive(1, 8'h12, 0, 0, 1, 1, 1, 1);
    cycle();
    cmp("lock_dest", 32'(dest), 32'h1);
    cmp("lock_d12", 32'(out1_data), 32'h12);
    drive(1, 8'h13, 1, 0, 1, 1, 1, 1);
    cycle();
    cmp("lock_d13", 32'(out1_data), 32'h13);
    cmp("lock_idle", 32'(busy), 32'h0);
    drive(1, 8'h20, 1, 0, 1, 1, 1, 1);
    cycle();
    cmp("after_ch2", 32'({out2_valid, out2_data}), 32'h120);
    drive(0, 8'h00, 0, 0, 0, 1, 1, 1);
    cycle();

    // backpressure on ch0, ch1 stays independent
    drive(1, 8'h55, 1, 0, 0, 0, 1, 1);
    cycle();
    drive(1, 8'h56, 1, 0, 0, 0, 1, 1);
    cycle();
    cmp("bp_ready", 32'(in_ready), 32'h0);
    cmp("bp_hold", 32'(out0_data), 32'h55);
    drive(1, 8'h77, 1, 1, 0, 0, 0, 1);
    cycle();
    cmp("ind_ch1", 32'(out1_data), 32'h77);
    cmp("ind_ch0", 32'({out0_valid, out0_data}), 32'h155);
    drive(1, 8'h56, 1, 0, 0, 1, 1, 1);
    cycle();
    cmp("bp_load", 32'({out0_valid, out0_data}), 32'h156);
    drive(0, 8'h00, 0, 0, 0, 1, 1, 1);
    cycle();

    // reset in the middle of a ch2 packet
    drive(1, 8'hC0, 0, 0, 1, 1, 1, 1);
    cycle();
    drive(1, 8'hC1, 0, 0, 1, 1, 1, 1);
    cycle();
    drive(0, 8'h00, 0, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    cmp("mrst_v2", 32'(out2_valid), 32'h0);
    check_outputs(0, 1'b1);
    #1 rst = 1'b0;
    @(negedge clk);
    drive(1, 8'h99, 1, 0, 0, 0, 0, 0);
    cycle();
    cmp("mrst_ch0", 32'({out0_valid, out0_data}), 32'h199);
    cmp("mrst_ch2", 32'(out2_valid), 32'h0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom),
            $urandom_range(0, 3) == 0,
            1'($urandom), 1'($urandom),
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
